// File: rtl/ps2_host_xmit.sv
// ps2_host_xmit: PS/2 host-to-device byte transmitter with filtered bus inputs,
// start/frame timeouts and automatic retries.
module ps2_host_xmit #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int INHIBIT_US   = 100,
  parameter int START_TMO_US = 15000,
  parameter int FRAME_TMO_US = 2000,
  parameter int MAX_RETRY    = 2,
  parameter int FILT_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drv_low,
  output logic       ps2_data_drv_low,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  output logic [2:0] retry_cnt
);
  localparam int MHZ   = CLK_HZ / 1_000_000;
  localparam int N_INH = (MHZ * INHIBIT_US > 0) ? MHZ * INHIBIT_US : 1;
  localparam int N_STA = (MHZ * START_TMO_US > 0) ? MHZ * START_TMO_US : 1;
  localparam int N_FRM = (MHZ * FRAME_TMO_US > 0) ? MHZ * FRAME_TMO_US : 1;
  localparam int N_M1  = (N_INH > N_STA) ? N_INH : N_STA;
  localparam int N_MAX = (N_M1 > N_FRM) ? N_M1 : N_FRM;
  localparam int TW    = $clog2(N_MAX + 1);
  localparam int FW    = $clog2(FILT_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, XFER, ACK, WAIT_IDLE, RETRY} state_t;
  state_t state, nxt;

  logic [1:0]         s1, s2, filt;
  logic [1:0][FW-1:0] fcnt;
  logic               clk_q, fall;
  logic [TW-1:0]      tmr, ftmr;
  logic [3:0]         cnt;
  logic [7:0]         data_q;
  logic               par, bit_q, err, t_exp, f_exp;
  logic [1:0]         code;

  // index 0 is the PS/2 clock, index 1 the data line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1    <= '1;
      s2    <= '1;
      filt  <= '1;
      fcnt  <= '0;
      clk_q <= 1'b1;
    end else begin
      s1    <= {ps2_data_in, ps2_clk_in};
      s2    <= s1;
      clk_q <= filt[0];
      for (int i = 0; i < 2; i++)
        if (s2[i] == filt[i]) fcnt[i] <= '0;
        else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else fcnt[i] <= fcnt[i] + FW'(1);
    end

  assign fall  = clk_q & ~filt[0];
  assign t_exp = tmr == TW'(1);
  assign f_exp = ftmr == TW'(1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt  = state;
    err  = 1'b0;
    code = 2'b00;
    case (state)
      IDLE:      if (tx_valid) nxt = INHIBIT;
      INHIBIT:   if (t_exp) nxt = REQ;
      REQ:       if (f_exp) {err, code} = 3'b110;
                 else if (fall) nxt = XFER;
                 else if (t_exp) {err, code} = 3'b101;
      XFER:      if (f_exp) {err, code} = 3'b110;
                 else if (fall && cnt == 4'd9) nxt = ACK;
      ACK:       if (f_exp) {err, code} = 3'b110;
                 else if (fall) {err, code, nxt} = filt[1] ? {3'b111, ACK} : {3'b000, WAIT_IDLE};
      WAIT_IDLE: if (f_exp) {err, code} = 3'b110;
                 else if (&filt) nxt = IDLE;
      RETRY:     nxt = INHIBIT;
      default:   nxt = IDLE;
    endcase
    if (err) nxt = (retry_cnt < 3'(MAX_RETRY)) ? RETRY : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tmr       <= '0;
      ftmr      <= '0;
      cnt       <= '0;
      data_q    <= '0;
      par       <= 1'b0;
      bit_q     <= 1'b1;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
      err_code  <= 2'b00;
      retry_cnt <= '0;
    end else begin
      tx_done <= state == WAIT_IDLE && nxt == IDLE;
      tx_err  <= err && nxt == IDLE;
      tmr     <= (state != INHIBIT && nxt == INHIBIT) ? TW'(N_INH) :
                 (state == INHIBIT && nxt == REQ) ? TW'(N_STA) :
                 (|tmr) ? tmr - TW'(1) : tmr;
      ftmr    <= (state == REQ && nxt == XFER) ? TW'(N_FRM) :
                 (nxt inside {XFER, ACK, WAIT_IDLE} && |ftmr) ? ftmr - TW'(1) :
                 (nxt inside {XFER, ACK, WAIT_IDLE}) ? ftmr : '0;
      // cnt counts falls since the start bit; bit_q is the level for the next bit slot
      if (nxt == INHIBIT) cnt <= '0;
      else if (fall && !err && state inside {REQ, XFER}) begin
        cnt   <= cnt + 4'd1;
        bit_q <= (cnt == 4'd9) ? 1'b1 : (cnt == 4'd8) ? par : data_q[cnt[2:0]];
      end
      if (state == IDLE && tx_valid) begin
        data_q    <= tx_data;
        par       <= ~^tx_data;
        retry_cnt <= '0;
        err_code  <= 2'b00;
      end
      if (err) err_code <= code;
      if (nxt == RETRY) retry_cnt <= retry_cnt + 3'd1;
    end

  assign tx_ready         = state == IDLE;
  assign tx_busy          = state != IDLE;
  assign ps2_clk_drv_low  = state == INHIBIT;
  assign ps2_data_drv_low = (state == INHIBIT && t_exp) || state == REQ || (state == XFER && !bit_q);
endmodule
